// File: rtl/port_ingress_buffer.sv
// Per-port ingress packet buffer: stores port words and exposes only fully received
// packets to the write arbiter, dropping any packet that cannot be held in full.
module port_ingress_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     next_data,
  output logic                     ready,
  output logic                     vld,
  output logic                     sop,
  output logic                     eop,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  output logic [1:0]               dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic [PW-1:0]          pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [DATA_WIDTH+1:0]  mem_q [DEPTH];

  logic                   we, commit, do_start, pop, pop_eop;
  logic [PW-1:0]          waddr, start_base;
  logic [DATA_WIDTH+1:0]  head;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic has_space(input logic [PW-1:0] base, input logic [PW-1:0] rd);
    logic [PW-1:0] used;
    used = base - rd;
    return used < DEPTH_P;
  endfunction

  // Ingress FSM. A new sop in RECV rolls back to the commit pointer and is then
  // handled exactly like a sop in IDLE, with space measured from the rollback.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    cm_d       = cm_q;
    drop_d     = drop_q;
    we         = 1'b0;
    commit     = 1'b0;
    waddr      = wr_q;
    do_start   = 1'b0;
    start_base = wr_q;
    if (in_vld) begin
      case (state_q)
        IDLE: if (in_sop) do_start = 1'b1;
        RECV: begin
          if (in_sop) begin
            drop_d     = sat_inc(drop_d);
            do_start   = 1'b1;
            start_base = cm_q;
          end else if (has_space(wr_q, rd_q)) begin
            we    = 1'b1;
            waddr = wr_q;
            wr_d  = wr_q + ONE_P;
            if (in_eop) begin
              commit  = 1'b1;
              cm_d    = wr_q + ONE_P;
              state_d = IDLE;
            end
          end else begin
            wr_d    = cm_q;
            drop_d  = sat_inc(drop_d);
            state_d = in_eop ? IDLE : DROP;
          end
        end
        DROP: begin
          if (in_sop) do_start = 1'b1;
          else if (in_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (do_start) begin
        if (has_space(start_base, rd_q)) begin
          we    = 1'b1;
          waddr = start_base;
          wr_d  = start_base + ONE_P;
          if (in_eop) begin
            commit  = 1'b1;
            cm_d    = start_base + ONE_P;
            state_d = IDLE;
          end else begin
            state_d = RECV;
          end
        end else begin
          wr_d    = start_base;
          drop_d  = sat_inc(drop_d);
          state_d = in_eop ? IDLE : DROP;
        end
      end
    end
  end

  // Egress: show-ahead head word straight from the array.
  assign head    = mem_q[rd_q[AW-1:0]];
  assign vld     = (rd_q != cm_q);
  assign sop     = vld & head[DATA_WIDTH+1];
  assign eop     = vld & head[DATA_WIDTH];
  assign data_out = vld ? head[DATA_WIDTH-1:0] : '0;
  assign pop     = next_data & vld;
  assign pop_eop = pop & head[DATA_WIDTH];
  assign rd_d    = pop ? rd_q + ONE_P : rd_q;

  always_comb begin
    pkt_d = pkt_q;
    case ({commit, pop_eop})
      2'b10:   pkt_d = pkt_q + ONE_P;
      2'b01:   pkt_d = pkt_q - ONE_P;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rd_q    <= rd_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr[AW-1:0]] <= {in_sop, in_eop, in_data};
  end

  assign ready       = (pkt_q != '0);
  assign level       = cm_q - rd_q;
  assign drop_cnt    = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_port_ingress_buffer.sv
// Directed bench for port_ingress_buffer: packet delivery, drops, wrap, abort, reset.
module tb_port_ingress_buffer;
  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          next_data = 1'b0;
  logic          ready, vld, sop, eop;
  logic [DW-1:0] data_out;
  logic [6:0]    level;
  logic [CW-1:0] drop_cnt;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drop = 0;
  logic [DW-1:0] exp_d;

  port_ingress_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .next_data(next_data), .ready(ready), .vld(vld), .sop(sop),
    .eop(eop), .data_out(data_out), .level(level), .drop_cnt(drop_cnt),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic e, input int d);
    in_vld = 1'b1; in_sop = s; in_eop = e; in_data = DW'(d);
    tick();
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int base);
    for (int i = 0; i < n; i++) send(i == 0, i == n - 1, base + i);
  endtask

  task automatic pop;
    next_data = 1'b1;
    tick();
    next_data = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got %0b exp 0", vld); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b exp 0", ready); end
    n_cmp++; if (level !== 7'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", level); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL rst_data got %0h exp 0", data_out); end
    n_cmp++; if ({sop, eop} !== 2'b00) begin n_err++; $display("FAIL rst_sopeop got %0b exp 00", {sop, eop}); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_basic;
    send(1'b1, 1'b0, 1); send(1'b0, 1'b0, 2); send(1'b0, 1'b0, 3);
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL basic_uncommitted_vld got %0b exp 0", vld); end
    send(1'b0, 1'b1, 4);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %0b exp 1", ready); end
    n_cmp++; if (level !== 7'd4) begin n_err++; $display("FAIL basic_level got %0d exp 4", level); end
    n_cmp++; if (sop !== 1'b1) begin n_err++; $display("FAIL basic_sop got %0b exp 1", sop); end
    for (int i = 1; i <= 4; i++) begin
      exp_d = DW'(i);
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL basic_data%0d got %0h exp %0h", i, data_out, exp_d); end
      n_cmp++; if (eop !== (i == 4)) begin n_err++; $display("FAIL basic_eop%0d got %0b exp %0b", i, eop, i == 4); end
      pop();
    end
    n_cmp++; if ({ready, vld} !== 2'b00) begin n_err++; $display("FAIL basic_empty got %0b exp 00", {ready, vld}); end
    n_cmp++; if (level !== 7'd0) begin n_err++; $display("FAIL basic_level_end got %0d exp 0", level); end
  endtask

  task automatic test_single;
    send(1'b1, 1'b1, 'hA5);
    n_cmp++; if (level !== 7'd1) begin n_err++; $display("FAIL single_level got %0d exp 1", level); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %0b exp 1", ready); end
    n_cmp++; if ({sop, eop} !== 2'b11) begin n_err++; $display("FAIL single_sopeop got %0b exp 11", {sop, eop}); end
    exp_d = DW'('hA5);
    n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL single_data got %0h exp %0h", data_out, exp_d); end
    pop();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL single_ready_after got %0b exp 0", ready); end
  endtask

  task automatic test_overflow_wrap;
    send_pkt(60, 'h100);
    send_pkt(8, 'h300);
    exp_drop++;
    n_cmp++; if (drop_cnt !== CW'(exp_drop)) begin n_err++; $display("FAIL ovf_drop got %0d exp %0d", drop_cnt, exp_drop); end
    n_cmp++; if (level !== 7'd60) begin n_err++; $display("FAIL ovf_level got %0d exp 60", level); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL ovf_state got %0d exp 0", dbg_state); end
    for (int i = 0; i < 60; i++) begin
      exp_d = DW'('h100 + i);
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL ovf_data%0d got %0h exp %0h", i, data_out, exp_d); end
      pop();
    end
    n_cmp++; if ({ready, vld} !== 2'b00) begin n_err++; $display("FAIL ovf_empty got %0b exp 00", {ready, vld}); end
    send_pkt(8, 'h200);
    n_cmp++; if (level !== 7'd8) begin n_err++; $display("FAIL wrap_level got %0d exp 8", level); end
    for (int i = 0; i < 8; i++) begin
      exp_d = DW'('h200 + i);
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_data%0d got %0h exp %0h", i, data_out, exp_d); end
      pop();
    end
  endtask

  task automatic test_long_packet;
    send_pkt(DEPTH + 1, 'h400);
    exp_drop++;
    n_cmp++; if (drop_cnt !== CW'(exp_drop)) begin n_err++; $display("FAIL long_drop got %0d exp %0d", drop_cnt, exp_drop); end
    n_cmp++; if ({vld, level} !== 8'd0) begin n_err++; $display("FAIL long_empty got %0b/%0d exp 0/0", vld, level); end
    send_pkt(DEPTH, 'h500);
    n_cmp++; if (level !== 7'd64) begin n_err++; $display("FAIL full_level got %0d exp 64", level); end
    n_cmp++; if (drop_cnt !== CW'(exp_drop)) begin n_err++; $display("FAIL full_drop got %0d exp %0d", drop_cnt, exp_drop); end
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = DW'('h500 + i);
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL full_data%0d got %0h exp %0h", i, data_out, exp_d); end
      pop();
    end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL full_ready_end got %0b exp 0", ready); end
  endtask

  task automatic test_abort;
    send(1'b1, 1'b0, 'h600); send(1'b0, 1'b0, 'h601); send(1'b0, 1'b0, 'h602);
    send_pkt(2, 'h700);
    exp_drop++;
    n_cmp++; if (drop_cnt !== CW'(exp_drop)) begin n_err++; $display("FAIL abort_drop got %0d exp %0d", drop_cnt, exp_drop); end
    n_cmp++; if (level !== 7'd2) begin n_err++; $display("FAIL abort_level got %0d exp 2", level); end
    exp_d = DW'('h700);
    n_cmp++; if ({sop, data_out} !== {1'b1, exp_d}) begin n_err++; $display("FAIL abort_head got %0b/%0h exp 1/%0h", sop, data_out, exp_d); end
    pop();
    exp_d = DW'('h701);
    n_cmp++; if ({eop, data_out} !== {1'b1, exp_d}) begin n_err++; $display("FAIL abort_tail got %0b/%0h exp 1/%0h", eop, data_out, exp_d); end
    pop();
  endtask

  task automatic test_back_to_back;
    send_pkt(2, 'h50);
    send(1'b1, 1'b0, 'h60);
    pop();
    // Pop the eop word of the first packet while the second one commits.
    in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = DW'('h61); next_data = 1'b1;
    tick();
    in_vld = 1'b0; in_eop = 1'b0; next_data = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %0b exp 1", ready); end
    n_cmp++; if (level !== 7'd2) begin n_err++; $display("FAIL b2b_level got %0d exp 2", level); end
    exp_d = DW'('h60);
    n_cmp++; if ({sop, data_out} !== {1'b1, exp_d}) begin n_err++; $display("FAIL b2b_head got %0b/%0h exp 1/%0h", sop, data_out, exp_d); end
    pop();
    n_cmp++; if ({ready, eop} !== 2'b11) begin n_err++; $display("FAIL b2b_mid got %0b exp 11", {ready, eop}); end
    pop();
    n_cmp++; if ({ready, vld} !== 2'b00) begin n_err++; $display("FAIL b2b_pktcnt got %0b exp 00", {ready, vld}); end
    pop();
    n_cmp++; if ({vld, level} !== 8'd0) begin n_err++; $display("FAIL empty_pop got %0b/%0d exp 0/0", vld, level); end
    send(1'b1, 1'b1, 'h70);
    exp_d = DW'('h70);
    n_cmp++; if ({level, data_out} !== {7'd1, exp_d}) begin n_err++; $display("FAIL empty_pop_next got %0d/%0h exp 1/%0h", level, data_out, exp_d); end
    pop();
  endtask

  task automatic test_reset_mid;
    send(1'b1, 1'b1, 'h10); send(1'b1, 1'b1, 'h11); send(1'b1, 1'b0, 'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_drop = 0;
    n_cmp++; if ({vld, ready} !== 2'b00) begin n_err++; $display("FAIL rstmid_vldrdy got %0b exp 00", {vld, ready}); end
    n_cmp++; if (level !== 7'd0) begin n_err++; $display("FAIL rstmid_level got %0d exp 0", level); end
    n_cmp++; if (drop_cnt !== CW'(exp_drop)) begin n_err++; $display("FAIL rstmid_drop got %0d exp 0", drop_cnt); end
    send(1'b0, 1'b1, 'h99);
    n_cmp++; if ({vld, level} !== 8'd0) begin n_err++; $display("FAIL nosop_ignored got %0b/%0d exp 0/0", vld, level); end
    send_pkt(3, 'h20);
    n_cmp++; if ({ready, level} !== {1'b1, 7'd3}) begin n_err++; $display("FAIL rstmid_pkt got %0b/%0d exp 1/3", ready, level); end
    for (int i = 0; i < 3; i++) begin
      exp_d = DW'('h20 + i);
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL rstmid_data%0d got %0h exp %0h", i, data_out, exp_d); end
      pop();
    end
    n_cmp++; if (drop_cnt !== CW'(exp_drop)) begin n_err++; $display("FAIL rstmid_drop_end got %0d exp 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow_wrap();
    test_long_packet();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
